// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_pkg
// Purpose  : Shared constants, state encoding and helpers for the fetch stage
//            and the pipeline registers reused further down the core.
// Contents : XLEN, NOP_INSTR_DEFAULT, RESET_PC_DEFAULT, fetch_state_t,
//            word_align()
// Revision : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0,x0,0 - the canonical bubble
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,  // request outstanding on pc
    ST_HOLD = 2'd1,  // fetched instruction parked while decode stalls
    ST_DROP = 2'd2   // stale request in flight, redirect target waiting
  } fetch_state_t;

  // Targets are silently word-aligned; no misalignment exception exists.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage : fetch_stage_pkg
`default_nettype wire

// File: rtl/if_dec_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_dec_reg
// Purpose  : Pipeline register carrying {instruction, pc, valid} between two
//            stages. Supports load, bubble insertion and hold.
// Ports    : clk, reset_n   - clock, asynchronous active-low reset
//            load           - capture load_instr/load_pc as a real instruction
//            bubble         - insert NOP (pc kept, valid cleared); beats load
//            load_instr/pc  - incoming instruction and its pc
//            instr/pc/valid - registered outputs to the next stage
// Revision : 1.0 - initial release
// ============================================================================
module if_dec_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic            bubble,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic            valid
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr <= NOP_INSTR;
      pc    <= '0;
      valid <= 1'b0;
    end else if (bubble) begin
      // pc is deliberately left alone so a bubble still carries a sane pc
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (load) begin
      instr <= load_instr;
      pc    <= load_pc;
      valid <= 1'b1;
    end
  end

endmodule : if_dec_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch. Owns the pc, keeps at most one instruction
//            memory request outstanding, parks a fetched instruction while
//            decode stalls, and discards in-flight data on redirects.
// Ports    : clk, reset_n            - clock, asynchronous active-low reset
//            fetch_ena, fetch_nop    - hazard control (advance / bubble)
//            redirect_valid/_pc      - taken branch/jump from execute
//            imem_req/_addr          - request to instruction memory
//            imem_rdata/_ready       - memory response
//            instr_dec/pc_dec/valid_dec - fetch/decode register outputs
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_ena,
  input  logic        fetch_nop,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instr_dec,
  output logic [31:0] pc_dec,
  output logic        valid_dec
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  hold_instr, hold_nxt;
  logic [31:0]  target, target_nxt;

  logic         complete;      // current request finishes this cycle
  logic         take;          // decode wants a real instruction this cycle
  logic [31:0]  redirect_aligned;

  logic         dec_load;
  logic         dec_bubble;
  logic [31:0]  dec_instr_d;

  assign take             = fetch_ena & ~fetch_nop;
  assign redirect_aligned = word_align(redirect_pc);
  assign complete         = (state != ST_HOLD) & imem_ready;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_REQ;
      pc         <= RESET_PC;
      hold_instr <= '0;
      target     <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      hold_instr <= hold_nxt;
      target     <= target_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    hold_nxt   = hold_instr;
    target_nxt = target;
    case (state)
      ST_REQ: begin
        if (complete) begin
          if (redirect_valid) begin
            pc_nxt = redirect_aligned;          // fetched data is wrong-path
          end else if (take) begin
            pc_nxt = pc + 32'd4;                // wraps modulo 2^32
          end else begin
            hold_nxt  = imem_rdata;
            state_nxt = ST_HOLD;
          end
        end else if (redirect_valid) begin
          // address must stay stable until the memory completes
          target_nxt = redirect_aligned;
          state_nxt  = ST_DROP;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_aligned;
          state_nxt = ST_REQ;
        end else if (take) begin
          pc_nxt    = pc + 32'd4;
          state_nxt = ST_REQ;
        end
      end
      ST_DROP: begin
        if (complete) begin
          // a redirect arriving with the stale completion is the newest target
          pc_nxt    = redirect_valid ? redirect_aligned : target;
          state_nxt = ST_REQ;
        end else if (redirect_valid) begin
          target_nxt = redirect_aligned;
        end
      end
      default: state_nxt = ST_REQ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    imem_req    = (state != ST_HOLD);
    imem_addr   = pc;
    dec_load    = 1'b0;
    dec_bubble  = 1'b0;
    dec_instr_d = imem_rdata;
    if (redirect_valid) begin
      dec_bubble = 1'b1;
    end else begin
      case (state)
        ST_REQ: begin
          if (complete && take) dec_load   = 1'b1;
          else if (fetch_ena)   dec_bubble = 1'b1;
        end
        ST_HOLD: begin
          dec_instr_d = hold_instr;
          if (take)           dec_load   = 1'b1;
          else if (fetch_ena) dec_bubble = 1'b1;
        end
        default: begin
          // nothing usable in flight: advancing decode only gets a bubble
          if (fetch_ena) dec_bubble = 1'b1;
        end
      endcase
    end
  end

  if_dec_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_dec_reg (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (dec_load),
    .bubble     (dec_bubble),
    .load_instr (dec_instr_d),
    .load_pc    (pc),
    .instr      (instr_dec),
    .pc         (pc_dec),
    .valid      (valid_dec)
  );

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage: directed scenarios with
//            literal expectations, then randomized traffic compared every
//            cycle against a buffer-level model of the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_ena = 1'b0;
  logic        fetch_nop = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready = 1'b0;
  logic [31:0] instr_dec;
  logic [31:0] pc_dec;
  logic        valid_dec;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // ROM: every word is its own address scrambled by a key
  assign imem_rdata = imem_addr ^ KEY;

  fetch_stage dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fetch_ena      (fetch_ena),
    .fetch_nop      (fetch_nop),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .instr_dec      (instr_dec),
    .pc_dec         (pc_dec),
    .valid_dec      (valid_dec)
  );

  // Model: next fetch address, an optional parked instruction, and a flag
  // saying the in-flight request is wrong-path and must be thrown away.
  logic [31:0] m_pc, m_held, m_target, m_instr, m_pcd;
  bit          m_held_valid, m_discard, m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_held = '0; m_target = '0;
    m_instr = NOP; m_pcd = '0; m_valid = 0;
    m_held_valid = 0; m_discard = 0;
  endtask

  task automatic model_tick(input bit ena, input bit nop, input bit redir,
                            input logic [31:0] rpc, input bit rdy);
    bit          complete, have;
    logic [31:0] data, avail, rtgt;
    complete = !m_held_valid && rdy;
    data     = m_pc ^ KEY;
    have     = m_held_valid || (complete && !m_discard);
    avail    = m_held_valid ? m_held : data;
    rtgt     = rpc & 32'hFFFF_FFFC;
    if (redir) begin
      m_instr = NOP; m_valid = 0;
      if (m_held_valid)  begin m_held_valid = 0; m_pc = rtgt; end
      else if (complete) begin m_pc = rtgt; m_discard = 0; end
      else               begin m_discard = 1; m_target = rtgt; end
    end else if (ena && !nop && have) begin
      m_instr = avail; m_pcd = m_pc; m_valid = 1;
      m_pc = m_pc + 32'd4;
      m_held_valid = 0;
    end else begin
      if (ena) begin m_instr = NOP; m_valid = 0; end
      if (complete && m_discard) begin m_pc = m_target; m_discard = 0; end
      else if (complete)         begin m_held_valid = 1; m_held = data; end
    end
  endtask

  task automatic compare_model();
    chk("instr_dec", instr_dec, m_instr);
    chk("pc_dec", pc_dec, m_pcd);
    chk("valid_dec", {31'b0, valid_dec}, {31'b0, m_valid});
    chk("imem_req", {31'b0, imem_req}, {31'b0, !m_held_valid});
    if (!m_held_valid) chk("imem_addr", imem_addr, m_pc);
  endtask

  // Drive one cycle of inputs at the falling edge, update the model at the
  // rising edge, compare at the next falling edge.
  task automatic step(input bit ena, input bit nop, input bit redir,
                      input logic [31:0] rpc, input bit rdy);
    fetch_ena = ena; fetch_nop = nop; redirect_valid = redir;
    redirect_pc = rpc; imem_ready = rdy;
    @(posedge clk);
    if (reset_n) model_tick(ena, nop, redir, rpc, rdy);
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    // reset values and first request
    chk("rst_instr", instr_dec, 32'h13);
    chk("rst_pc_dec", pc_dec, 32'h0);
    chk("rst_valid", {31'b0, valid_dec}, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h1);
    chk("rst_addr", imem_addr, 32'h0);
    compare_model();

    // zero-wait stream
    step(1, 0, 0, 0, 1);
    chk("first_instr", instr_dec, 32'hA5A5_0000);
    chk("first_pc", pc_dec, 32'h0);
    chk("first_valid", {31'b0, valid_dec}, 32'h1);
    chk("first_addr", imem_addr, 32'h4);
    step(1, 0, 0, 0, 1);
    chk("second_instr", instr_dec, 32'hA5A5_0004);
    chk("second_addr", imem_addr, 32'h8);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    chk("addr_10", imem_addr, 32'h10);

    // stall three cycles at pc 0x10
    step(0, 0, 0, 0, 1);
    chk("stall_req", {31'b0, imem_req}, 32'h0);
    chk("stall_instr", instr_dec, 32'hA5A5_000C);
    chk("stall_pc", pc_dec, 32'hC);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("stall3_req", {31'b0, imem_req}, 32'h0);
    chk("stall3_instr", instr_dec, 32'hA5A5_000C);
    step(1, 0, 0, 0, 1);
    chk("release_instr", instr_dec, 32'hA5A5_0010);
    chk("release_pc", pc_dec, 32'h10);
    chk("release_addr", imem_addr, 32'h14);

    // redirect in a zero-wait stream
    step(1, 0, 1, 32'h200, 1);
    chk("redir_valid", {31'b0, valid_dec}, 32'h0);
    chk("redir_instr", instr_dec, 32'h13);
    chk("redir_addr", imem_addr, 32'h200);
    step(1, 0, 0, 0, 1);
    chk("redir_target_instr", instr_dec, 32'hA5A5_0200);

    // redirect while memory waits
    step(1, 0, 1, 32'h300, 0);
    chk("drop_addr0", imem_addr, 32'h204);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0);
      chk("drop_addr", imem_addr, 32'h204);
    end
    step(1, 0, 0, 0, 1);
    chk("drop_no_stale", {31'b0, valid_dec}, 32'h0);
    chk("drop_new_addr", imem_addr, 32'h300);
    step(1, 0, 0, 0, 1);
    chk("drop_target_instr", instr_dec, 32'hA5A5_0300);
    chk("drop_target_pc", pc_dec, 32'h300);

    // wrap and alignment
    step(1, 0, 1, 32'hFFFF_FFFC, 1);
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 1);
    chk("top_instr", instr_dec, 32'h5A5A_FFFC);
    chk("wrap_addr", imem_addr, 32'h0);
    step(1, 0, 1, 32'h0000_0102, 1);
    chk("align_addr", imem_addr, 32'h100);
    step(1, 0, 0, 0, 1);
    chk("align_pc", pc_dec, 32'h100);

    // asynchronous reset in the middle of a wait
    step(1, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_instr", instr_dec, 32'h13);
    chk("arst_pc_dec", pc_dec, 32'h0);
    chk("arst_valid", {31'b0, valid_dec}, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    repeat (2) @(negedge clk);
    compare_model();
    reset_n = 1'b1;
    step(1, 0, 0, 0, 1);
    chk("post_rst_addr", imem_addr, 32'h4);
    chk("post_rst_instr", instr_dec, 32'hA5A5_0000);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] rp;
      rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15))
                                       : $urandom;
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 11) == 0,
           rp,
           $urandom_range(0, 9) < 7);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_fetch_stage
`default_nettype wire
